ppi_group_ctrl: RTL and testbench

PPI_GROUP_CTRL -- requirements
Module: ppi_group_ctrl

---
 rtl/ppi_group_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_ppi_group_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ppi_group_ctrl.sv
// Group A control of an 8255-style parallel peripheral interface.
// Decodes mode-set and bit-set/reset control words, drives port C upper
// direction and values, and runs the mode-1 strobed input handshake on port A
// (STB on PC4, IBF on PC5, INTE_A set through the PC4 bit-set command).
module ppi_group_ctrl #(
  parameter int PORT_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_ctrl,
  input  logic [7:0]        ctrl_word,
  input  logic              stb_n,
  input  logic              rd_a,
  input  logic [PORT_W-1:0] port_a_in,
  output logic [1:0]        mode_a,
  output logic              a_dir,
  output logic              cu_dir,
  output logic [3:0]        pc_out,
  output logic [3:0]        pc_oe,
  output logic [PORT_W-1:0] a_latch,
  output logic              ibf,
  output logic              intr,
  output logic              inte,
  output logic              ctrl_err
);

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;

  // Strobe synchroniser and edge detector state. Both reset high so that the
  // first cycles after reset never look like a strobe edge.
  logic [SYNC_STAGES-1:0] stb_meta;
  logic                   stb_dly;
  logic                   stb_s;
  logic                   stb_fall;
  logic                   stb_rise;

  // Architectural registers
  logic [1:0]        mode_r;
  logic              a_dir_r;
  logic              cu_dir_r;
  logic [3:0]        pc_r;
  logic [PORT_W-1:0] latch_r;
  logic              ibf_r;
  logic              intr_r;
  logic              inte_r;
  logic              err_r;

  // Next-state values
  logic [1:0]        mode_n;
  logic              a_dir_n;
  logic              cu_dir_n;
  logic [3:0]        pc_n;
  logic [PORT_W-1:0] latch_n;
  logic              ibf_n;
  logic              intr_n;
  logic              inte_n;
  logic              err_n;

  logic              is_mode1;
  logic              mode_ok;
  logic [2:0]        bsr_idx;

  // Shift the asynchronous strobe through the synchroniser, keep last sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stb_meta <= '1;
      stb_dly  <= 1'b1;
    end else begin
      stb_meta <= {stb_meta[SYNC_STAGES-2:0], stb_n};
      stb_dly  <= stb_meta[SYNC_STAGES-1];
    end
  end

  assign stb_s    = stb_meta[SYNC_STAGES-1];
  assign stb_fall = stb_dly & ~stb_s;
  assign stb_rise = ~stb_dly & stb_s;

  assign is_mode1 = (mode_r == MODE1);
  // Only mode 0 (either direction) and mode 1 input are supported.
  assign mode_ok  = ~ctrl_word[6] & (~ctrl_word[5] | ctrl_word[4]);
  assign bsr_idx  = ctrl_word[3:1];

  // Next-state: handshake events first, then the control word on top of them
  always_comb begin
    mode_n   = mode_r;
    a_dir_n  = a_dir_r;
    cu_dir_n = cu_dir_r;
    pc_n     = pc_r;
    latch_n  = latch_r;
    ibf_n    = ibf_r;
    intr_n   = intr_r;
    inte_n   = inte_r;
    err_n    = 1'b0;

    if (is_mode1) begin
      if (rd_a) begin
        ibf_n  = 1'b0;
        intr_n = 1'b0;
      end
      // A capture beats a coincident read: data is new and still unread.
      if (stb_fall) begin
        latch_n = port_a_in;
        ibf_n   = 1'b1;
      end
      if (stb_rise && ibf_r && inte_r && !rd_a) begin
        intr_n = 1'b1;
      end
    end

    if (wr_ctrl) begin
      if (ctrl_word[7]) begin
        if (mode_ok) begin
          mode_n   = ctrl_word[6:5];
          a_dir_n  = ctrl_word[4];
          cu_dir_n = ctrl_word[3];
          pc_n     = 4'b0000;
          latch_n  = '0;
          ibf_n    = 1'b0;
          intr_n   = 1'b0;
          inte_n   = 1'b0;
        end else begin
          err_n = 1'b1;
        end
      end else if (bsr_idx[2]) begin
        // In mode 1 the PC4 bit-set command addresses INTE_A, not the pin.
        if (is_mode1 && (bsr_idx[1:0] == 2'd0)) begin
          inte_n = ctrl_word[0];
          if (!ctrl_word[0]) begin
            intr_n = 1'b0;
          end else if (ibf_n && stb_s) begin
            intr_n = 1'b1;
          end
        end else begin
          pc_n[bsr_idx[1:0]] = ctrl_word[0];
        end
      end
    end
  end

  // Register all control and handshake state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_r   <= MODE0;
      a_dir_r  <= 1'b1;
      cu_dir_r <= 1'b1;
      pc_r     <= 4'b0000;
      latch_r  <= '0;
      ibf_r    <= 1'b0;
      intr_r   <= 1'b0;
      inte_r   <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      mode_r   <= mode_n;
      a_dir_r  <= a_dir_n;
      cu_dir_r <= cu_dir_n;
      pc_r     <= pc_n;
      latch_r  <= latch_n;
      ibf_r    <= ibf_n;
      intr_r   <= intr_n;
      inte_r   <= inte_n;
      err_r    <= err_n;
    end
  end

  assign mode_a   = mode_r;
  assign a_dir    = a_dir_r;
  assign cu_dir   = cu_dir_r;
  assign a_latch  = latch_r;
  assign ibf      = ibf_r;
  assign intr     = intr_r;
  assign inte     = inte_r;
  assign ctrl_err = err_r;

  // PC4 is the strobe input and PC5 carries IBF while in mode 1; the reset
  // state (mode 0, cu_dir=1) naturally yields all enables low.
  assign pc_out = is_mode1 ? {pc_r[3:2], ibf_r, pc_r[0]} : pc_r;
  assign pc_oe  = is_mode1 ? {{2{~cu_dir_r}}, 1'b1, 1'b0} : {4{~cu_dir_r}};

endmodule

// File: tb/tb_ppi_group_ctrl.sv
// Directed bench for ppi_group_ctrl: control-word table plus mode-1
// handshake sequences and an asynchronous reset in mid-transfer.
module tb_ppi_group_ctrl;

  localparam int PORT_W = 8;
  localparam int SYNC_STAGES = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_ctrl;
  logic [7:0]        ctrl_word;
  logic              stb_n;
  logic              rd_a;
  logic [PORT_W-1:0] port_a_in;
  logic [1:0]        mode_a;
  logic              a_dir;
  logic              cu_dir;
  logic [3:0]        pc_out;
  logic [3:0]        pc_oe;
  logic [PORT_W-1:0] a_latch;
  logic              ibf;
  logic              intr;
  logic              inte;
  logic              ctrl_err;

  int n_chk  = 0;
  int n_fail = 0;

  ppi_group_ctrl #(.PORT_W(PORT_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .rst(rst), .wr_ctrl(wr_ctrl), .ctrl_word(ctrl_word),
    .stb_n(stb_n), .rd_a(rd_a), .port_a_in(port_a_in),
    .mode_a(mode_a), .a_dir(a_dir), .cu_dir(cu_dir), .pc_out(pc_out),
    .pc_oe(pc_oe), .a_latch(a_latch), .ibf(ibf), .intr(intr),
    .inte(inte), .ctrl_err(ctrl_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] cw;
    logic [1:0] mode;
    logic       a_dir;
    logic       cu_dir;
    logic [3:0] pc;
    logic [3:0] oe;
    logic       inte;
    logic       err;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic write_cw(input logic [7:0] cw);
    wr_ctrl = 1'b1;
    ctrl_word = cw;
    tick();
    wr_ctrl = 1'b0;
    ctrl_word = 8'h00;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_mode"}, 32'(mode_a), 32'h0);
    chk({tag, "_a_dir"}, 32'(a_dir), 32'h1);
    chk({tag, "_cu_dir"}, 32'(cu_dir), 32'h1);
    chk({tag, "_pc_out"}, 32'(pc_out), 32'h0);
    chk({tag, "_pc_oe"}, 32'(pc_oe), 32'h0);
    chk({tag, "_a_latch"}, 32'(a_latch), 32'h0);
    chk({tag, "_ibf"}, 32'(ibf), 32'h0);
    chk({tag, "_intr"}, 32'(intr), 32'h0);
    chk({tag, "_inte"}, 32'(inte), 32'h0);
    chk({tag, "_err"}, 32'(ctrl_err), 32'h0);
  endtask

  initial begin
    // cw, mode, a_dir, cu_dir, pc_out, pc_oe, inte, ctrl_err
    vecs[0]  = '{8'h80, 2'b00, 1'b0, 1'b0, 4'b0000, 4'b1111, 1'b0, 1'b0};
    vecs[1]  = '{8'h0F, 2'b00, 1'b0, 1'b0, 4'b1000, 4'b1111, 1'b0, 1'b0};
    vecs[2]  = '{8'h09, 2'b00, 1'b0, 1'b0, 4'b1001, 4'b1111, 1'b0, 1'b0};
    vecs[3]  = '{8'h03, 2'b00, 1'b0, 1'b0, 4'b1001, 4'b1111, 1'b0, 1'b0};
    vecs[4]  = '{8'h0D, 2'b00, 1'b0, 1'b0, 4'b1101, 4'b1111, 1'b0, 1'b0};
    vecs[5]  = '{8'h0E, 2'b00, 1'b0, 1'b0, 4'b0101, 4'b1111, 1'b0, 1'b0};
    vecs[6]  = '{8'hC0, 2'b00, 1'b0, 1'b0, 4'b0101, 4'b1111, 1'b0, 1'b1};
    vecs[7]  = '{8'hA0, 2'b00, 1'b0, 1'b0, 4'b0101, 4'b1111, 1'b0, 1'b1};
    vecs[8]  = '{8'h00, 2'b00, 1'b0, 1'b0, 4'b0101, 4'b1111, 1'b0, 1'b0};
    vecs[9]  = '{8'h88, 2'b00, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0};
    vecs[10] = '{8'hB0, 2'b01, 1'b1, 1'b0, 4'b0000, 4'b1110, 1'b0, 1'b0};
    vecs[11] = '{8'h09, 2'b01, 1'b1, 1'b0, 4'b0000, 4'b1110, 1'b1, 1'b0};
    vecs[12] = '{8'h0B, 2'b01, 1'b1, 1'b0, 4'b0000, 4'b1110, 1'b1, 1'b0};

    rst = 1'b1;
    wr_ctrl = 1'b0;
    ctrl_word = 8'h00;
    stb_n = 1'b1;
    rd_a = 1'b0;
    port_a_in = '0;
    ticks(2);
    chk_reset_vals("reset");
    rst = 1'b0;
    tick();

    // Control-word table
    for (int i = 0; i < 13; i++) begin
      write_cw(vecs[i].cw);
      chk($sformatf("vec%0d_mode", i), 32'(mode_a), 32'(vecs[i].mode));
      chk($sformatf("vec%0d_a_dir", i), 32'(a_dir), 32'(vecs[i].a_dir));
      chk($sformatf("vec%0d_cu_dir", i), 32'(cu_dir), 32'(vecs[i].cu_dir));
      chk($sformatf("vec%0d_pc_out", i), 32'(pc_out), 32'(vecs[i].pc));
      chk($sformatf("vec%0d_pc_oe", i), 32'(pc_oe), 32'(vecs[i].oe));
      chk($sformatf("vec%0d_inte", i), 32'(inte), 32'(vecs[i].inte));
      chk($sformatf("vec%0d_err", i), 32'(ctrl_err), 32'(vecs[i].err));
      chk($sformatf("vec%0d_ibf", i), 32'(ibf), 32'h0);
      chk($sformatf("vec%0d_intr", i), 32'(intr), 32'h0);
      chk($sformatf("vec%0d_latch", i), 32'(a_latch), 32'h0);
    end
    // Mode 1, inte=1; PC7 set (PC5 bit stored but shown as IBF)
    write_cw(8'h0F);
    chk("m1_pc_out_pc7", 32'(pc_out), 32'b1000);

    // Strobed capture: latency SYNC_STAGES+1, interrupt after rising edge
    port_a_in = 8'hA5;
    stb_n = 1'b0;
    tick();
    chk("cap_t1_ibf", 32'(ibf), 32'h0);
    tick();
    chk("cap_t2_ibf", 32'(ibf), 32'h0);
    tick();
    chk("cap_t3_ibf", 32'(ibf), 32'h1);
    chk("cap_t3_latch", 32'(a_latch), 32'hA5);
    chk("cap_t3_intr", 32'(intr), 32'h0);
    chk("cap_t3_pc_out", 32'(pc_out), 32'b1010);
    port_a_in = 8'h3C;
    tick();
    stb_n = 1'b1;
    ticks(2);
    chk("rise_t2_intr", 32'(intr), 32'h0);
    chk("rise_t2_latch", 32'(a_latch), 32'hA5);
    tick();
    chk("rise_t3_intr", 32'(intr), 32'h1);
    rd_a = 1'b1;
    tick();
    rd_a = 1'b0;
    chk("rd_ibf", 32'(ibf), 32'h0);
    chk("rd_intr", 32'(intr), 32'h0);
    chk("rd_latch", 32'(a_latch), 32'hA5);
    chk("rd_pc_out", 32'(pc_out), 32'b1000);

    // Build ibf=1, intr=1, then read coincident with the next synced fall
    port_a_in = 8'h11;
    stb_n = 1'b0;
    ticks(3);
    stb_n = 1'b1;
    ticks(3);
    chk("pre_rdcap_intr", 32'(intr), 32'h1);
    stb_n = 1'b0;
    ticks(2);
    rd_a = 1'b1;
    port_a_in = 8'h5A;
    tick();
    rd_a = 1'b0;
    chk("rdcap_ibf", 32'(ibf), 32'h1);
    chk("rdcap_intr", 32'(intr), 32'h0);
    chk("rdcap_latch", 32'(a_latch), 32'h5A);

    // Overwrite while full
    stb_n = 1'b1;
    ticks(3);
    stb_n = 1'b0;
    port_a_in = 8'h77;
    ticks(3);
    chk("ovw_latch", 32'(a_latch), 32'h77);
    chk("ovw_ibf", 32'(ibf), 32'h1);

    // INTE control through PC4 bit-set
    stb_n = 1'b1;
    ticks(3);
    write_cw(8'h08);
    chk("inte_clr_inte", 32'(inte), 32'h0);
    chk("inte_clr_intr", 32'(intr), 32'h0);
    chk("inte_clr_pc_out", 32'(pc_out), 32'b1010);
    write_cw(8'h09);
    chk("inte_set_inte", 32'(inte), 32'h1);
    chk("inte_set_intr", 32'(intr), 32'h1);

    // Mode set coincident with a capture: the clear wins
    stb_n = 1'b0;
    ticks(2);
    port_a_in = 8'h99;
    write_cw(8'hB0);
    chk("wrlast_ibf", 32'(ibf), 32'h0);
    chk("wrlast_latch", 32'(a_latch), 32'h0);
    chk("wrlast_inte", 32'(inte), 32'h0);
    chk("wrlast_pc_out", 32'(pc_out), 32'b0000);

    // Reach ibf=1, intr=1 and reset asynchronously mid-cycle
    write_cw(8'h09);
    stb_n = 1'b1;
    ticks(3);
    stb_n = 1'b0;
    ticks(3);
    stb_n = 1'b1;
    ticks(3);
    chk("prerst_ibf", 32'(ibf), 32'h1);
    chk("prerst_intr", 32'(intr), 32'h1);
    chk("prerst_latch", 32'(a_latch), 32'h99);
    #3;
    rst = 1'b1;
    #1;
    chk_reset_vals("async_rst");
    #2;
    rst = 1'b0;
    ticks(4);
    chk_reset_vals("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
